// File: rtl/dqs_burst_seq.sv
// DQS burst sequencer: per-lane DQS din/tin words and DCI disable
// for read/write bursts, with preamble, postamble and seamless reload.
module dqs_burst_seq #(
  parameter int NUM_LANES   = 2,
  parameter int BURST_WIDTH = 6,
  parameter int WR_PRE      = 1,
  parameter int WR_POST     = 1,
  parameter int DCI_LEAD    = 2,
  parameter int DCI_TAIL    = 2
) (
  input  logic                   clk_div,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rd,
  input  logic [BURST_WIDTH-1:0] burst_cnt,
  input  logic [NUM_LANES-1:0]   lane_en,
  output logic                   ready,
  output logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic                   dci_disable,
  output logic [4*NUM_LANES-1:0] din,
  output logic [4*NUM_LANES-1:0] tin
);

  localparam int M1 = (WR_PRE > WR_POST) ? WR_PRE : WR_POST;
  localparam int M2 = (DCI_LEAD > DCI_TAIL) ? DCI_LEAD : DCI_TAIL;
  localparam int PM = (M1 > M2) ? M1 : M2;
  localparam int PW = $clog2(PM + 1);
  localparam int CW = (BURST_WIDTH > PW) ? BURST_WIDTH : PW;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_WPRE = CW'(WR_PRE);
  localparam logic [CW-1:0] C_WPST = CW'(WR_POST);
  localparam logic [CW-1:0] C_RPRE = CW'(DCI_LEAD);
  localparam logic [CW-1:0] C_RPST = CW'(DCI_TAIL);

  typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   mode;
  logic [NUM_LANES-1:0]   lanes;
  logic [BURST_WIDTH-1:0] blen;

  logic          last;
  logic          acc;
  logic [CW-1:0] pre;
  logic [CW-1:0] post;

  assign last  = (cnt == C_ONE);
  assign ready = (state == IDLE) || (state == DATA && last);
  assign acc   = start && ready && (burst_cnt != '0) &&
                 ((state != DATA) || (rd == mode));
  assign pre   = rd ? C_RPRE : C_WPRE;
  assign post  = mode ? C_RPST : C_WPST;

  // Output word for the state being entered: {dci_disable, din, tin}
  function automatic logic [8*NUM_LANES:0] words(
    input state_t               st,
    input logic                 md,
    input logic [NUM_LANES-1:0] ln
  );
    logic [4*NUM_LANES-1:0] d;
    logic [4*NUM_LANES-1:0] t;
    d = '0;
    t = '1;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (ln[k] && !md && st != IDLE) begin
        t[4*k +: 4] = 4'b0000;
        if (st == DATA) d[4*k +: 4] = 4'b0101;
      end
    end
    return {!(md && st != IDLE), d, t};
  endfunction

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      lanes <= '0;
      blen  <= '0;
      ack   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      {dci_disable, din, tin} <= words(IDLE, 1'b0, '0);
    end else begin
      ack  <= acc;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            state <= LEAD;
            cnt   <= pre;
            mode  <= rd;
            lanes <= lane_en;
            blen  <= burst_cnt;
            busy  <= 1'b1;
            {dci_disable, din, tin} <= words(LEAD, rd, lane_en);
          end
        end
        LEAD: begin
          if (last) begin
            state <= DATA;
            cnt   <= CW'(blen);
            {dci_disable, din, tin} <= words(DATA, mode, lanes);
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        DATA: begin
          if (last && acc) begin
            cnt   <= CW'(burst_cnt);
            lanes <= lane_en;
            blen  <= burst_cnt;
            {dci_disable, din, tin} <= words(DATA, mode, lane_en);
          end else if (last) begin
            state <= TAIL;
            cnt   <= post;
            done  <= (post == C_ONE);
            {dci_disable, din, tin} <= words(TAIL, mode, lanes);
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        TAIL: begin
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            {dci_disable, din, tin} <= words(IDLE, mode, lanes);
          end else begin
            cnt  <= cnt - C_ONE;
            done <= (cnt == C_TWO);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dqs_burst_seq.md
Name: dqs_burst_seq

Overview:
- Parametrised multi-lane DQS burst sequencer running in the clk_div domain.
- Generates the 4-bit-per-lane parallel DQS data and tristate words that feed the per-lane DQS OSERDES inputs (din/tin).
- Generates the DCI termination disable for reads and writes, with configurable preamble, postamble and DCI lead/tail.
- Supports seamless back-to-back bursts of the same direction.

Parameters:
- NUM_LANES, 2, number of DQS byte lanes driven.
- BURST_WIDTH, 6, width of burst_cnt (length in clk_div words).
- WR_PRE, 1, write preamble length in clk_div words (>=1).
- WR_POST, 1, write postamble length in clk_div words (>=1).
- DCI_LEAD, 2, read: cycles DCI is enabled before the data window (>=1).
- DCI_TAIL, 2, read: cycles DCI stays enabled after the data window (>=1).

Ports:
- clk_div  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  burst request; qualified by ready.
- rd  input  1  direction of request: 1 = read, 0 = write.
- burst_cnt  input  BURST_WIDTH  data-window length in clk_div words; 0 = invalid.
- lane_en  input  NUM_LANES  per-lane enable, latched on acceptance.
- ready  output  1  combinational: request can be accepted this cycle.
- ack  output  1  registered one-cycle pulse, cycle after acceptance.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on the transition TAIL->IDLE.
- dci_disable  output  1  to the lane IOBUFs; 0 = DCI termination on.
- din  output  4*NUM_LANES  DQS parallel data, lane k at [4k+3:4k], bit0 serialized first.
- tin  output  4*NUM_LANES  DQS parallel tristate, same layout; 1 = Hi-Z.

Behaviour:
- Clocking and reset: single clock, clk_div; reset is asynchronous and active-high on rst. All outputs registered except ready.
- Reset values: state IDLE, din all 0, tin all 1, dci_disable 1, busy 0, ack 0, done 0. Asserting rst mid-burst returns these values immediately, with no postamble.
- FSM states: IDLE, LEAD, DATA, TAIL. One down-counter cnt, wide enough for max(BURST_WIDTH, param widths).
- Acceptance: acc = start & ready & (burst_cnt != 0). ready = (state==IDLE) | (state==DATA & cnt==1).
  - In DATA, acc additionally requires rd == latched mode. Otherwise the request is dropped, with no ack.
- On acc from IDLE: latch mode=rd and lanes=lane_en; go to LEAD with cnt = WR_PRE (write) or DCI_LEAD (read). Outputs change on the next edge (latency 1).
- LEAD: cnt counts to 1, then DATA with cnt = latched burst_cnt.
- DATA: at cnt==1, either
  - acc (same mode): reload cnt = burst_cnt, re-latch lanes, stay in DATA. This is seamless, with no gap word.
  - no acc: go to TAIL with cnt = WR_POST or DCI_TAIL.
- TAIL: at cnt==1 go to IDLE and pulse done.
- Output words for enabled lanes:
  - Write: LEAD din=0000 tin=0000; DATA din=0101 tin=0000; TAIL din=0000 tin=0000; dci_disable=1 throughout.
  - Read: tin=1111 and din=0000 in all states; dci_disable=0 in LEAD, DATA and TAIL.
  - IDLE: din=0000, tin=1111, dci_disable=1.
- Disabled lanes (latched lane_en bit 0): always din=0000, tin=1111.
- dci_disable is a single global signal and ignores lanes.
- start with burst_cnt=0: ignored in every state, no ack, no state change.
- start while busy and not ready: ignored, with no queuing.
- No combinational path from any input to registered outputs.

Test Plan:
- Reset mid-write DATA (burst_cnt=4, cycle 3) -> same cycle tin=all 1, din=0, dci_disable=1, busy=0; no done.
- Write, NUM_LANES=2, lane_en=2'b11, burst_cnt=2, defaults -> ack at T+1. Then from T+1:
  - 1 cycle din=0x00 tin=0x00;
  - 2 cycles din=0x55 tin=0x00;
  - 1 cycle din=0x00 tin=0x00;
  - then tin=0xFF; done high in the postamble cycle; busy high for 4 cycles.
- Read burst_cnt=3, lane_en=2'b01 -> tin=0xFF throughout; dci_disable=0 for 2+3+2=7 cycles, starting T+1; done on the 7th.
- Seamless: write burst_cnt=2, then start (rd=0, burst_cnt=1) in the last DATA cycle -> 3 consecutive din=0x55 words, one preamble, one postamble, two acks, one done.
- Mode mismatch: read start in the last write DATA cycle -> no ack, normal postamble then IDLE. Start with burst_cnt=0 in IDLE -> no ack, busy stays 0.
- Lane change on a seamless reload (2'b11 -> 2'b10) -> lane 0 goes tin=1111 and lane 1 keeps 0101 from the first reloaded word.
